// File: rtl/mem_axi_bridge_pkg.sv
// Shared definitions for the MEM-stage to AXI bridge: FSM encoding,
// AXI size codes, fixed AXI attribute values and request decode helpers.
package mem_axi_bridge_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;
    localparam int ID_W   = 4;

    localparam logic [ID_W-1:0] DEFAULT_DATA_ID = 4'h1;

    // AXI arsize/awsize codes
    localparam logic [2:0] SIZE_BYTE = 3'd0;
    localparam logic [2:0] SIZE_HALF = 3'd1;
    localparam logic [2:0] SIZE_WORD = 3'd2;

    localparam logic [1:0] BURST_INCR = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RADDR = 3'd1,
        ST_RDATA = 3'd2,
        ST_WADDR = 3'd3,
        ST_WRESP = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Byte-enable mask to AXI transfer size; irregular masks fall back to a word.
    function automatic logic [2:0] size_from_dre(input logic [STRB_W-1:0] dre);
        logic [2:0] size;
        case (dre)
            4'b1111:                            size = SIZE_WORD;
            4'b0011, 4'b1100:                   size = SIZE_HALF;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size = SIZE_BYTE;
            default:                            size = SIZE_WORD;
        endcase
        return size;
    endfunction

    // Clear the address bits below the transfer size.
    function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] addr,
                                                     input logic [2:0]        size);
        logic [ADDR_W-1:0] aligned;
        case (size)
            SIZE_BYTE: aligned = addr;
            SIZE_HALF: aligned = {addr[ADDR_W-1:1], 1'b0};
            default:   aligned = {addr[ADDR_W-1:2], 2'b00};
        endcase
        return aligned;
    endfunction

endpackage

// File: rtl/mem_axi_bridge.sv
// Bridges single MEM-stage loads/stores onto a single-beat AXI master port.
// One transaction outstanding at a time; the pipeline is stalled until the
// one-cycle DONE state. A flush lets the bus transfer finish but drops load data.
module mem_axi_bridge
    import mem_axi_bridge_pkg::*;
#(
    parameter logic [3:0] DATA_ID = DEFAULT_DATA_ID
) (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst_n,

    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [3:0]  mem_dre,
    input  logic [31:0] mem_wdata,
    input  logic        flush,
    output logic [31:0] dm,
    output logic        mem_stop_wb,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    state_t      state_q;
    logic [31:0] addr_q;
    logic [2:0]  size_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [31:0] rbuf_q;
    logic        flushed_q;
    logic        arvalid_q;
    logic        rready_q;
    logic        awvalid_q;
    logic        wvalid_q;
    logic        bready_q;

    logic [2:0]  size_d;
    logic [31:0] addr_d;
    logic        aw_done;
    logic        w_done;
    logic        discard_r;

    // Response IDs and error codes are deliberately ignored: every response completes.
    logic        unused_resp_fields;
    assign unused_resp_fields = ^{rid, rresp, bid, bresp};

    // Request decode, latched on the IDLE exit.
    assign size_d = size_from_dre(mem_dre);
    assign addr_d = align_addr(mem_addr, size_d);

    // A channel counts as done once its handshake has happened, either earlier or now.
    assign aw_done   = !awvalid_q || awready;
    assign w_done    = !wvalid_q  || wready;
    assign discard_r = flush || flushed_q;

    // Transaction FSM with registered AXI valid/ready outputs.
    // NOTE: every state element here uses non-blocking assignment so all
    // registers update from the same pre-edge values, as real flops do.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            size_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rbuf_q    <= '0;
            flushed_q <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mem_req && !flush) begin
                        addr_q    <= addr_d;
                        size_q    <= size_d;
                        wdata_q   <= mem_wdata;
                        wstrb_q   <= mem_dre;
                        flushed_q <= 1'b0;
                        if (mem_we) begin
                            state_q   <= ST_WADDR;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                        end else begin
                            state_q   <= ST_RADDR;
                            arvalid_q <= 1'b1;
                        end
                    end
                end
                ST_RADDR: begin
                    if (arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    if (rvalid && rlast) begin
                        rready_q <= 1'b0;
                        if (!discard_r) begin
                            rbuf_q <= rdata;
                        end
                        state_q <= ST_DONE;
                    end
                end
                ST_WADDR: begin
                    if (awvalid_q && awready) begin
                        awvalid_q <= 1'b0;
                    end
                    if (wvalid_q && wready) begin
                        wvalid_q <= 1'b0;
                    end
                    if (aw_done && w_done) begin
                        bready_q <= 1'b1;
                        state_q  <= ST_WRESP;
                    end
                end
                ST_WRESP: begin
                    if (bvalid) begin
                        bready_q <= 1'b0;
                        state_q  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase

            // Remember a flush seen mid-transaction so late read data is still dropped.
            if (flush && state_q != ST_IDLE) begin
                flushed_q <= 1'b1;
            end
        end
    end

    assign mem_stop_wb = mem_req && (state_q != ST_DONE) && !flush;
    assign dm          = rbuf_q;

    assign arid    = DATA_ID;
    assign araddr  = addr_q;
    assign arlen   = 8'd0;
    assign arsize  = size_q;
    assign arburst = BURST_INCR;
    assign arlock  = 1'b0;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign arvalid = arvalid_q;
    assign rready  = rready_q;

    assign awid    = DATA_ID;
    assign awaddr  = addr_q;
    assign awlen   = 8'd0;
    assign awsize  = size_q;
    assign awburst = BURST_INCR;
    assign awlock  = 1'b0;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign awvalid = awvalid_q;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign wlast   = 1'b1;
    assign wvalid  = wvalid_q;
    assign bready  = bready_q;

endmodule

// File: tb/tb_mem_axi_bridge.sv
// Directed bench for mem_axi_bridge: loads, stores, handshake orderings,
// flush behaviour and asynchronous reset, with hand-computed expectations.
module tb_mem_axi_bridge;

    logic        clk;
    logic        rst_n;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_dre;
    logic [31:0] mem_wdata;
    logic        flush;
    logic [31:0] dm;
    logic        mem_stop_wb;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    int checks = 0;
    int errors = 0;

    mem_axi_bridge dut (
        .cpu_clk_50M (clk),
        .cpu_rst_n   (rst_n),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_dre     (mem_dre),
        .mem_wdata   (mem_wdata),
        .flush       (flush),
        .dm          (dm),
        .mem_stop_wb (mem_stop_wb),
        .arid        (arid),
        .araddr      (araddr),
        .arlen       (arlen),
        .arsize      (arsize),
        .arburst     (arburst),
        .arlock      (arlock),
        .arcache     (arcache),
        .arprot      (arprot),
        .arvalid     (arvalid),
        .arready     (arready),
        .rid         (rid),
        .rdata       (rdata),
        .rresp       (rresp),
        .rlast       (rlast),
        .rvalid      (rvalid),
        .rready      (rready),
        .awid        (awid),
        .awaddr      (awaddr),
        .awlen       (awlen),
        .awsize      (awsize),
        .awburst     (awburst),
        .awlock      (awlock),
        .awcache     (awcache),
        .awprot      (awprot),
        .awvalid     (awvalid),
        .awready     (awready),
        .wdata       (wdata),
        .wstrb       (wstrb),
        .wlast       (wlast),
        .wvalid      (wvalid),
        .wready      (wready),
        .bid         (bid),
        .bresp       (bresp),
        .bvalid      (bvalid),
        .bready      (bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven and outputs sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single load with immediate arready and rvalid one cycle later.
    task automatic run_load(input string tag, input logic [31:0] addr, input logic [3:0] dre,
                            input logic [31:0] data, input logic [31:0] exp_addr,
                            input logic [2:0] exp_size);
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = addr; mem_dre = dre;
        tick();
        check({tag, ".arvalid"}, {31'd0, arvalid}, 32'd1);
        check({tag, ".araddr"}, araddr, exp_addr);
        check({tag, ".arsize"}, {29'd0, arsize}, {29'd0, exp_size});
        arready = 1'b1;
        tick();
        arready = 1'b0;
        check({tag, ".rready"}, {31'd0, rready}, 32'd1);
        rvalid = 1'b1; rlast = 1'b1; rdata = data;
        tick();
        rvalid = 1'b0; rlast = 1'b0;
        check({tag, ".dm"}, dm, data);
        check({tag, ".done_stall"}, {31'd0, mem_stop_wb}, 32'd0);
        mem_req = 1'b0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_dre = '0; mem_wdata = '0;
        flush = 1'b0;
        arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bid = '0; bresp = '0; bvalid = 1'b0;

        // Reset state and tied-off attributes
        #12;
        check("rst.dm", dm, 32'd0);
        check("rst.valids", {27'd0, arvalid, awvalid, wvalid, rready, bready}, 32'd0);
        check("rst.stall", {31'd0, mem_stop_wb}, 32'd0);
        check("rst.arlen", {24'd0, arlen}, 32'd0);
        check("rst.burst", {28'd0, arburst, awburst}, 32'h5);
        check("rst.ids", {24'd0, arid, awid}, 32'h11);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        check("rel.valids", {29'd0, arvalid, awvalid, wvalid}, 32'd0);

        // Word load: arready two cycles late, data three cycles after that
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h8000_0010; mem_dre = 4'b1111;
        #1;
        check("ld.stall_idle", {31'd0, mem_stop_wb}, 32'd1);
        tick();
        check("ld.arvalid", {31'd0, arvalid}, 32'd1);
        check("ld.araddr", araddr, 32'h8000_0010);
        check("ld.arsize", {29'd0, arsize}, 32'd2);
        mem_addr = 32'h1234_5678; mem_dre = 4'b0001;
        tick();
        check("ld.araddr_held", araddr, 32'h8000_0010);
        check("ld.arsize_held", {29'd0, arsize}, 32'd2);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        check("ld.ar_drop", {31'd0, arvalid}, 32'd0);
        check("ld.rready", {31'd0, rready}, 32'd1);
        tick();
        tick();
        check("ld.stall_wait", {31'd0, mem_stop_wb}, 32'd1);
        rvalid = 1'b1; rlast = 1'b1; rdata = 32'hDEAD_BEEF;
        tick();
        rvalid = 1'b0; rlast = 1'b0;
        check("ld.dm", dm, 32'hDEAD_BEEF);
        check("ld.done_stall", {31'd0, mem_stop_wb}, 32'd0);
        check("ld.rready_drop", {31'd0, rready}, 32'd0);
        mem_req = 1'b0;
        tick();
        check("ld.idle", {31'd0, arvalid}, 32'd0);

        // Halfword store: wready before awready, error response
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h8000_0022; mem_dre = 4'b1100;
        mem_wdata = 32'h1234_0000;
        tick();
        check("st.valids", {30'd0, awvalid, wvalid}, 32'd3);
        check("st.awaddr", awaddr, 32'h8000_0022);
        check("st.awsize", {29'd0, awsize}, 32'd1);
        check("st.wstrb", {28'd0, wstrb}, 32'hC);
        check("st.wdata", wdata, 32'h1234_0000);
        check("st.wlast", {31'd0, wlast}, 32'd1);
        wready = 1'b1;
        tick();
        wready = 1'b0;
        check("st.w_only", {30'd0, awvalid, wvalid}, 32'd2);
        check("st.bready_early", {31'd0, bready}, 32'd0);
        awready = 1'b1;
        tick();
        awready = 1'b0;
        check("st.aw_drop", {31'd0, awvalid}, 32'd0);
        check("st.bready", {31'd0, bready}, 32'd1);
        check("st.stall_resp", {31'd0, mem_stop_wb}, 32'd1);
        bvalid = 1'b1; bresp = 2'b10;
        tick();
        bvalid = 1'b0; bresp = 2'b00;
        check("st.done_stall", {31'd0, mem_stop_wb}, 32'd0);
        check("st.bready_drop", {31'd0, bready}, 32'd0);
        check("st.dm_kept", dm, 32'hDEAD_BEEF);
        mem_req = 1'b0;
        tick();

        // Store with both handshakes in the first WADDR cycle: DONE in the third cycle
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h0000_0103; mem_dre = 4'b1111;
        mem_wdata = 32'hCAFE_F00D;
        tick();
        check("fs.awaddr", awaddr, 32'h0000_0100);
        check("fs.awsize", {29'd0, awsize}, 32'd2);
        awready = 1'b1; wready = 1'b1;
        tick();
        awready = 1'b0; wready = 1'b0;
        check("fs.valids_drop", {30'd0, awvalid, wvalid}, 32'd0);
        check("fs.stall2", {31'd0, mem_stop_wb}, 32'd1);
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        check("fs.done3", {31'd0, mem_stop_wb}, 32'd0);
        mem_req = 1'b0;
        tick();

        // Flush during RDATA: handshake completes, data dropped, stall released
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h2000_0004; mem_dre = 4'b1111;
        tick();
        arready = 1'b1;
        tick();
        arready = 1'b0;
        check("fl.rready", {31'd0, rready}, 32'd1);
        flush = 1'b1; rvalid = 1'b1; rlast = 1'b1; rdata = 32'h5555_5555;
        #1;
        check("fl.stall", {31'd0, mem_stop_wb}, 32'd0);
        tick();
        flush = 1'b0; rvalid = 1'b0; rlast = 1'b0; mem_req = 1'b0;
        check("fl.rready_drop", {31'd0, rready}, 32'd0);
        check("fl.dm_kept", dm, 32'hDEAD_BEEF);
        tick();

        // Flush in IDLE blocks the start of a transaction
        mem_req = 1'b1; mem_we = 1'b0; flush = 1'b1; mem_addr = 32'h3000_0000;
        tick();
        check("fi.no_ar", {31'd0, arvalid}, 32'd0);
        check("fi.stall", {31'd0, mem_stop_wb}, 32'd0);
        mem_req = 1'b0; flush = 1'b0;
        tick();

        // Size decode and address alignment
        run_load("byte", 32'h0000_1003, 4'b0100, 32'h0000_00A5, 32'h0000_1003, 3'd0);
        run_load("half", 32'h0000_1003, 4'b0011, 32'h0000_5A5A, 32'h0000_1002, 3'd1);
        run_load("odd",  32'h0000_1003, 4'b0110, 32'h0F0F_0F0F, 32'h0000_1000, 3'd2);

        // Asynchronous reset in WADDR
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h4000_0000; mem_dre = 4'b1111;
        mem_wdata = 32'h1111_2222;
        tick();
        check("rw.awvalid", {31'd0, awvalid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rw.valids_drop", {30'd0, awvalid, wvalid}, 32'd0);
        check("rw.dm", dm, 32'd0);
        check("rw.awaddr", awaddr, 32'd0);
        mem_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        check("rw.rel_valids", {29'd0, arvalid, awvalid, wvalid}, 32'd0);
        run_load("post", 32'h0000_2000, 4'b1111, 32'h7777_8888, 32'h0000_2000, 3'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "time limit");
    end

endmodule
